// File: rtl/x2c_rx_buf_pkg.sv
// x2c_pkg: shared widths, lane codes, read-state encoding and the
// data-buffer entry layout for the x2c receive buffer.
package x2c_pkg;
  localparam int DATA_W = 256;
  localparam int CTRL_W = 32;
  localparam int BCNT_W = 32;

  // Start-lane codes carried in x_byte_cnt[31:24].
  localparam logic [7:0] LANE0 = 8'h01;
  localparam logic [7:0] LANE4 = 8'h02;

  typedef enum logic [2:0] {
    RD_IDLE = 3'h1,
    RD_HEAD = 3'h2,
    RD_XFER = 3'h4
  } rd_state_e;

  typedef struct packed {
    logic              eop;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } buf_entry_t;
endpackage

// File: rtl/x2c_rx_buf_if.sv
// x2c_rx_buf_if: packet stream from the receive buffer to the core.
//   rx_data/rx_ctrl : word and per-byte ctrl bits
//   rx_valid/rx_ready : handshake, word moves on valid & ready
//   rx_sop/rx_eop   : packet framing
//   rx_byte_cnt     : byte-count word, stable for the whole packet
// master = buffer side, slave = core side.
interface x2c_rx_buf_if;
  import x2c_pkg::*;
  logic [DATA_W-1:0] rx_data;
  logic [CTRL_W-1:0] rx_ctrl;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_sop;
  logic              rx_eop;
  logic [BCNT_W-1:0] rx_byte_cnt;

  modport master (output rx_data, rx_ctrl, rx_valid, rx_sop, rx_eop, rx_byte_cnt,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_ctrl, rx_valid, rx_sop, rx_eop, rx_byte_cnt,
                  output rx_ready);
endinterface

// File: rtl/x2c_rx_buf_bcnt_fifo.sv
// x2c_bcnt_fifo: plain synchronous FIFO, W bits wide, 2^ALOG2 deep.
//   push/din  : write when not full
//   pop/dout  : dout shows the head entry; pop advances when not empty
//   full/empty: occupancy flags from the current pointers
module x2c_bcnt_fifo #(
  parameter int W     = 32,
  parameter int ALOG2 = 4
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**ALOG2];
  logic [ALOG2:0] wp, rp;

  // Extra pointer bit distinguishes full from empty.
  assign full  = (wp[ALOG2] != rp[ALOG2]) && (wp[ALOG2-1:0] == rp[ALOG2-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[ALOG2-1:0]];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[ALOG2-1:0]] <= din;
  end
endmodule

// File: rtl/x2c_rx_buf.sv
// x2c_rx_buf: receive packet buffer behind the serial-to-parallel stage.
// Stores whole packets, drops partial/overflowing ones, and releases only
// committed packets as a valid/ready stream with sop/eop framing.
//   clk, reset_        : clock, async active-low reset
//   linkup             : 0 aborts the packet being written
//   data_in/ctrl_in    : incoming word, written on x_we
//   x_bcnt_we          : marks the last word; x_byte_cnt captured with it
//   rx (master)        : outgoing packet stream
//   drop_pulse/drop_cnt: per-drop pulse and saturating drop counter
module x2c_rx_buf
  import x2c_pkg::*;
#(
  parameter int DLOG2 = 6,
  parameter int BLOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              linkup,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              x_we,
  input  logic              x_bcnt_we,
  input  logic [BCNT_W-1:0] x_byte_cnt,
  x2c_rx_buf_if.master      rx,
  output logic              drop_pulse,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 2**DLOG2;
  typedef logic [DLOG2:0] ptr_t;

  buf_entry_t mem [DEPTH];
  ptr_t       wr_ptr, cmt_ptr, rd_ptr;
  logic       discard;
  logic       full;

  logic              bf_full, bf_empty, bf_pop;
  logic [BCNT_W-1:0] bf_dout;

  logic wr_en, commit, drop, rewind, disc_set, disc_clr;

  // rd_ptr is the one registered before this edge, so a same-cycle read
  // never frees space for the write: full is conservative.
  assign full = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);

  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    rewind   = 1'b0;
    disc_set = 1'b0;
    disc_clr = 1'b0;
    if (!linkup) begin
      // A packet cut off by link loss (partly written or being discarded)
      // never sees its eop, so it is counted here.
      if ((wr_ptr != cmt_ptr) || discard) begin
        rewind = 1'b1;
        drop   = 1'b1;
      end
      disc_clr = discard;
    end else if (x_we) begin
      if (discard) begin
        if (x_bcnt_we) begin
          disc_clr = 1'b1;
          drop     = 1'b1;
        end
      end else if (full) begin
        rewind = 1'b1;
        // Overflow on the last word itself: drop now, nothing left to skip.
        if (x_bcnt_we) drop = 1'b1;
        else           disc_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (x_bcnt_we) begin
          if (bf_full) begin
            rewind = 1'b1;
            drop   = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      discard    <= 1'b0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (rewind)     wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit)     cmt_ptr <= wr_ptr + 1'b1;
      if (disc_set)      discard <= 1'b1;
      else if (disc_clr) discard <= 1'b0;
      drop_pulse <= drop;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DLOG2-1:0]] <= '{eop: x_bcnt_we, ctrl: ctrl_in, data: data_in};
  end

  x2c_bcnt_fifo #(.W(BCNT_W), .ALOG2(BLOG2)) u_bcnt_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (commit),
    .din    (x_byte_cnt),
    .pop    (bf_pop),
    .dout   (bf_dout),
    .full   (bf_full),
    .empty  (bf_empty)
  );

  // Read side. Only committed packets have a byte count, and reading stops
  // at eop, so rd_ptr can never run past cmt_ptr.
  rd_state_e  st;
  buf_entry_t rd_ent;

  assign rd_ent = mem[rd_ptr[DLOG2-1:0]];
  assign bf_pop = (st == RD_HEAD);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      st             <= RD_IDLE;
      rd_ptr         <= '0;
      rx.rx_data     <= '0;
      rx.rx_ctrl     <= '0;
      rx.rx_valid    <= 1'b0;
      rx.rx_sop      <= 1'b0;
      rx.rx_eop      <= 1'b0;
      rx.rx_byte_cnt <= '0;
    end else begin
      case (st)
        RD_IDLE: if (!bf_empty) st <= RD_HEAD;
        RD_HEAD: begin
          rx.rx_byte_cnt <= bf_dout;
          rx.rx_data     <= rd_ent.data;
          rx.rx_ctrl     <= rd_ent.ctrl;
          rx.rx_valid    <= 1'b1;
          rx.rx_sop      <= 1'b1;
          rx.rx_eop      <= rd_ent.eop;
          rd_ptr         <= rd_ptr + 1'b1;
          st             <= RD_XFER;
        end
        RD_XFER: begin
          if (rx.rx_valid && rx.rx_ready) begin
            if (!rx.rx_eop) begin
              rx.rx_data <= rd_ent.data;
              rx.rx_ctrl <= rd_ent.ctrl;
              rx.rx_sop  <= 1'b0;
              rx.rx_eop  <= rd_ent.eop;
              rd_ptr     <= rd_ptr + 1'b1;
            end else begin
              // HEAD is the one-cycle bubble between packets.
              rx.rx_valid <= 1'b0;
              rx.rx_sop   <= 1'b0;
              rx.rx_eop   <= 1'b0;
              st          <= bf_empty ? RD_IDLE : RD_HEAD;
            end
          end
        end
        default: st <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: doc/x2c_rx_buf.md
Name: x2c_rx_buf

Overview:
Receive-side packet buffer directly downstream of the 10G serial-to-parallel stage. Accepts the 256-bit data/32-bit ctrl word stream (x_we) and the per-packet byte-count word (x_bcnt_we/x_byte_cnt), stores whole packets, and drops partial or overflowing ones. Releases only fully committed packets to the core as a valid/ready stream with sop/eop framing.

Parameters:
DLOG2, 6, log2 of data/ctrl buffer depth in 256-bit words (64 words)
BLOG2, 4, log2 of byte-count FIFO depth in packets (16 packets)

Ports:
clk  in  1  core clock, rising edge
reset_  in  1  asynchronous active-low reset
linkup  in  1  link status from upstream; 0 aborts any packet being written
data_in  in  256  parallel data word
ctrl_in  in  32  parallel ctrl bits, 1 bit per byte
x_we  in  1  data/ctrl word write strobe
x_bcnt_we  in  1  byte-count strobe; coincides with x_we of the packet's last word
x_byte_cnt  in  32  [15:0] byte count, [31:24] start lane code (01 = lane 0, 02 = lane 4), [23:16] zero
rx_data  out  256  output data word
rx_ctrl  out  32  output ctrl word
rx_valid  out  1  output word valid
rx_ready  in  1  core accepts the word when rx_valid & rx_ready
rx_sop  out  1  first word of packet
rx_eop  out  1  last word of packet
rx_byte_cnt  out  32  byte-count word of current packet; stable from sop through eop
drop_pulse  out  1  one-cycle pulse per dropped packet
drop_cnt  out  16  dropped packets, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): all pointers 0; state IDLE; rx_valid, rx_sop, rx_eop, drop_pulse = 0; rx_data, rx_ctrl, rx_byte_cnt, drop_cnt = 0.
- Data buffer: 2^DLOG2 entries of {eop_flag, ctrl, data}. eop_flag = x_bcnt_we at write time.
- Pointers are DLOG2+1 bits. wr_ptr is speculative. cmt_ptr is committed. rd_ptr belongs to the reader. Full = (wr_ptr - rd_ptr) == 2^DLOG2. Wrap is natural modulo 2^(DLOG2+1).
- Write side, per x_we:
  - Buffer not full and not in DISCARD: write the entry and increment wr_ptr.
  - x_we while full: enter DISCARD and restore wr_ptr to cmt_ptr.
  - DISCARD ignores x_we until the x_we & x_bcnt_we cycle. That cycle counts one drop and returns to normal.
- Commit: x_we & x_bcnt_we, not discarding, data written, byte-count FIFO not full. Then cmt_ptr <= wr_ptr + 1 and {x_byte_cnt} is pushed to the byte-count FIFO.
  - If the byte-count FIFO is full at that edge: restore wr_ptr to cmt_ptr and count one drop.
- linkup = 0 while wr_ptr != cmt_ptr: restore wr_ptr to cmt_ptr, count one drop. Writes are ignored while linkup = 0.
- x_bcnt_we without x_we is ignored.
- Drop: drop_pulse = 1 for one cycle; drop_cnt += 1, saturating.
- Read FSM (states IDLE, HEAD, XFER):
  - IDLE: when the byte-count FIFO is not empty, go to HEAD.
  - HEAD: pop the byte count into rx_byte_cnt. Load the entry at rd_ptr into the output register with rx_valid = 1 and rx_sop = 1. rd_ptr += 1. Go to XFER.
  - XFER: on rx_valid & rx_ready, load the next entry (rx_sop = 0, rx_eop = its eop_flag) and increment rd_ptr, unless the accepted word had eop.
    - If eop was accepted and the byte-count FIFO is not empty: go to HEAD. If empty: rx_valid = 0, go to IDLE.
    - The reader never passes cmt_ptr.
  - A single-word packet has rx_sop = rx_eop = 1.
- While rx_valid = 1 and rx_ready = 0: rx_data, rx_ctrl, rx_sop, rx_eop and rx_byte_cnt hold unchanged.
- Latency: commit edge at cycle T; first word valid at cycle T+3 when the reader is IDLE. Back-to-back packets leave one bubble cycle (HEAD).
- Simultaneous read and write at full: the write sees full computed before that edge's read, so full is conservative.
- Throughput: one word per cycle in and out.

Decomposition:
- Package x2c_pkg: DATA_W = 256, CTRL_W = 32, BCNT_W = 32; lane codes LANE0 = 8'h01, LANE4 = 8'h02; read-state encoding (IDLE/HEAD/XFER, one-hot 3'h1/3'h2/3'h4).
- Sub-module x2c_bcnt_fifo: plain synchronous FIFO, width 32, depth 2^BLOG2, with push/pop/full/empty. Reused later on the TX side.
- The data buffer stays inline because of its commit/rewind pointers.

Test Plan:
1. Single 3-word packet; eop word written with x_byte_cnt = 32'h0100_0050 at cycle T; rx_ready = 1.
   -> rx_valid from T+3 for 3 cycles; sop on word 1, eop on word 3; rx_byte_cnt = 32'h0100_0050; data bit-exact.
2. Two back-to-back 2-word packets; rx_ready toggles 1,0,1,0.
   -> Outputs hold during ready = 0; one HEAD bubble between packets; order preserved; drop_cnt = 0.
3. DLOG2 = 2 (4 words), rx_ready = 0, 6-word packet.
   -> Overflow on word 5; wr_ptr rewound; drop_pulse once on the eop write; drop_cnt = 1.
   -> A following 2-word packet is then delivered intact once rx_ready = 1.
4. BLOG2 = 1, rx_ready = 0, three 1-word packets.
   -> First two commit; third is dropped (drop_cnt = 1); exactly two packets are delivered later.
5. linkup drops after word 2 of a 4-word packet.
   -> Packet discarded; drop_cnt = 1; no output.
   -> After linkup returns, the next packet is delivered with sop on its first word.
6. reset_ asserted mid-output-packet.
   -> All outputs 0 immediately (async); after release, the buffer is empty and rx_valid stays 0 until a new commit.
